// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: active-low 4-digit multiplexed seven-segment driver.
// The one-hot ring counter state selects the digit. Display data is
// double-buffered and committed only at frame start (state == 1000).
// Ring states with more than one bit set blank the outputs and set a
// sticky error flag.
module seg7_scan_drv (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  state,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        err
);

  logic [15:0] sh_val;
  logic [3:0]  sh_dp;
  logic        pend;
  logic [15:0] disp_val;
  logic [3:0]  disp_dp;

  logic [15:0] disp_val_nxt;
  logic [3:0]  disp_dp_nxt;
  logic        pend_nxt;

  logic        frame_start;
  logic        onehot;
  logic        idle;
  logic [1:0]  dsel;
  logic [3:0]  nib;
  logic [3:1]  zero_from;
  logic        blank;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;

  // Hex glyphs, segments {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign frame_start = (state == 4'b1000);

  // Commit logic: a load at frame start bypasses the shadow; otherwise a
  // pending shadow is promoted at frame start.
  always_comb begin
    disp_val_nxt = disp_val;
    disp_dp_nxt  = disp_dp;
    pend_nxt     = pend;
    if (load) begin
      pend_nxt = 1'b1;
    end
    if (frame_start) begin
      if (load) begin
        disp_val_nxt = din;
        disp_dp_nxt  = dp_mask;
        pend_nxt     = 1'b0;
      end else if (pend) begin
        disp_val_nxt = sh_val;
        disp_dp_nxt  = sh_dp;
        pend_nxt     = 1'b0;
      end
    end
  end

  // Digit select, leading-zero blanking and glyph decode of the
  // post-commit display value.
  always_comb begin
    idle   = (state == 4'b0000);
    onehot = !idle && ((state & (state - 4'd1)) == 4'b0000);
    case (state)
      4'b0010: dsel = 2'd1;
      4'b0100: dsel = 2'd2;
      4'b1000: dsel = 2'd3;
      default: dsel = 2'd0;
    endcase
    nib = disp_val_nxt[{dsel, 2'b00} +: 4];

    zero_from[3] = (disp_val_nxt[15:12] == 4'h0);
    zero_from[2] = zero_from[3] && (disp_val_nxt[11:8] == 4'h0);
    zero_from[1] = zero_from[2] && (disp_val_nxt[7:4] == 4'h0);

    case (dsel)
      2'd3:    blank = blank_lz && zero_from[3];
      2'd2:    blank = blank_lz && zero_from[2];
      2'd1:    blank = blank_lz && zero_from[1];
      default: blank = 1'b0;
    endcase

    an_nxt  = '1;
    seg_nxt = '1;
    dp_nxt  = 1'b1;
    if (onehot) begin
      an_nxt  = ~state;
      seg_nxt = blank ? 7'b1111111 : glyph(nib);
      dp_nxt  = ~disp_dp_nxt[dsel];
    end
  end

  // Buffer, display, output and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_val   <= '0;
      sh_dp    <= '0;
      pend     <= 1'b0;
      disp_val <= '0;
      disp_dp  <= '0;
      an       <= '1;
      seg      <= '1;
      dp       <= 1'b1;
      err      <= 1'b0;
    end else begin
      if (load) begin
        sh_val <= din;
        sh_dp  <= dp_mask;
      end
      pend     <= pend_nxt;
      disp_val <= disp_val_nxt;
      disp_dp  <= disp_dp_nxt;
      an       <= an_nxt;
      seg      <= seg_nxt;
      dp       <= dp_nxt;
      if (!onehot && !idle) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb_seg7_scan_drv: directed scenarios plus randomized traffic checked
// against a behavioural model of the display driver.
module tb_seg7_scan_drv;

  logic        clk;
  logic        reset;
  logic [3:0]  state;
  logic        load;
  logic [15:0] din;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state and expected outputs.
  int unsigned m_sh, m_shdp, m_disp, m_ddp;
  bit          m_pend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_err;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_drv dut (
    .clk      (clk),
    .reset    (reset),
    .state    (state),
    .load     (load),
    .din      (din),
    .dp_mask  (dp_mask),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, update the model from the inputs seen at the edge,
  // then settle so outputs can be sampled away from the edge.
  task automatic tick();
    int nbits;
    int idx;
    int unsigned upper;
    @(posedge clk);
    if (reset) begin
      m_sh = 0; m_shdp = 0; m_pend = 0; m_disp = 0; m_ddp = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_err = 1'b0;
    end else begin
      if (state == 4'b1000 && load) begin
        m_disp = din; m_ddp = dp_mask; m_pend = 0;
        m_sh = din; m_shdp = dp_mask;
      end else begin
        if (state == 4'b1000 && m_pend) begin
          m_disp = m_sh; m_ddp = m_shdp; m_pend = 0;
        end
        if (load) begin
          m_sh = din; m_shdp = dp_mask; m_pend = 1;
        end
      end
      nbits = $countones(state);
      idx = 0;
      for (int k = 0; k < 4; k++) if (state[k]) idx = k;
      if (nbits == 1) begin
        upper = m_disp >> (4 * idx);
        e_an  = ~state;
        if (blank_lz && idx > 0 && upper == 0) e_seg = 7'h7F;
        else e_seg = glyph_tab[upper % 16];
        e_dp = ((m_ddp >> idx) & 1) == 0;
      end else begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (nbits > 1) e_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic set_digit(input int d);
    state = 4'(1 << d);
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; state = 4'b0000;
    din = '0; dp_mask = '0; blank_lz = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if ({an, seg, dp, err} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got an=%b seg=%b dp=%b err=%b, want 1111 1111111 1 0", an, seg, dp, err);
    end
  endtask

  task automatic test_frame();
    logic [3:0] want_an [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    for (int d = 3; d >= 0; d--) begin
      set_digit(d);
      tick();
      n_checks++;
      if (an !== want_an[3 - d] || seg !== 7'b1000000) begin
        n_fail++;
        $display("FAIL frame_digit%0d: got an=%b seg=%b, want an=%b seg=1000000", d, an, seg, want_an[3 - d]);
      end
    end
  endtask

  task automatic test_load_mid();
    logic [6:0] want [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    for (int d = 3; d >= 0; d--) begin
      set_digit(d);
      load = (d == 2); din = 16'h1234; dp_mask = 4'b0000;
      tick();
      load = 1'b0;
      n_checks++;
      if (seg !== 7'b1000000) begin
        n_fail++;
        $display("FAIL load_mid_curframe_d%0d: got seg=%b, want 1000000", d, seg);
      end
    end
    for (int d = 3; d >= 0; d--) begin
      set_digit(d);
      tick();
      n_checks++;
      if (seg !== want[d]) begin
        n_fail++;
        $display("FAIL load_mid_next_d%0d: got seg=%b, want %b", d, seg, want[d]);
      end
    end
  endtask

  task automatic test_load_at_fs();
    logic [6:0] want [4] = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000};
    set_digit(1); load = 1'b1; din = 16'h5555; tick();
    load = 1'b0;
    set_digit(0); tick();
    for (int d = 3; d >= 0; d--) begin
      set_digit(d);
      load = (d == 3); din = 16'hABCD;
      tick();
      load = 1'b0;
      n_checks++;
      if (an !== ~state || seg !== want[d]) begin
        n_fail++;
        $display("FAIL load_at_fs_d%0d: got an=%b seg=%b, want an=%b seg=%b", d, an, seg, ~state, want[d]);
      end
    end
  endtask

  task automatic test_lz();
    logic [6:0] want_seg [4] = '{7'b1000000, 7'b1111000, 7'b1111111, 7'b1111111};
    logic       want_dp  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    blank_lz = 1'b1;
    for (int d = 3; d >= 0; d--) begin
      set_digit(d);
      load = (d == 3); din = 16'h0070; dp_mask = 4'b1000;
      tick();
      load = 1'b0;
      n_checks++;
      if (an !== ~state || seg !== want_seg[d] || dp !== want_dp[d]) begin
        n_fail++;
        $display("FAIL lz_d%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b", d, an, seg, dp, ~state, want_seg[d], want_dp[d]);
      end
    end
    blank_lz = 1'b0; dp_mask = 4'b0000;
  endtask

  task automatic test_illegal();
    state = 4'b0110;
    tick();
    n_checks++;
    if ({an, seg, err} !== {4'b1111, 7'b1111111, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal_state: got an=%b seg=%b err=%b, want 1111 1111111 1", an, seg, err);
    end
    for (int d = 3; d >= 0; d--) begin
      set_digit(d);
      tick();
      n_checks++;
      if (an !== ~state || err !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_resume_d%0d: got an=%b err=%b, want an=%b err=1", d, an, err, ~state);
      end
    end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++;
    if (err !== 1'b0 || an !== 4'b1111) begin
      n_fail++;
      $display("FAIL illegal_reset_clear: got err=%b an=%b, want err=0 an=1111", err, an);
    end
  endtask

  task automatic test_idle();
    state = 4'b0000; load = 1'b1; din = 16'hFFFF; dp_mask = 4'b0000;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({an, seg, dp, err} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_off_%0d: got an=%b seg=%b dp=%b err=%b, want 1111 1111111 1 0", i, an, seg, dp, err);
      end
    end
    set_digit(3);
    tick();
    n_checks++;
    if (an !== 4'b0111 || seg !== 7'b0001110) begin
      n_fail++;
      $display("FAIL idle_release: got an=%b seg=%b, want an=0111 seg=0001110", an, seg);
    end
  endtask

  task automatic test_random();
    int pos = 3;
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) < 2);
      load     = ($urandom_range(0, 99) < 20);
      din      = 16'($urandom);
      dp_mask  = 4'($urandom);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 99) < 4) begin
        state = 4'($urandom);
      end else begin
        set_digit(pos);
        pos = (pos == 0) ? 3 : pos - 1;
      end
      if ($urandom_range(0, 3) == 0) din[15:8] = 8'h00;
      tick();
      n_checks++;
      if ({an, seg, dp, err} !== {e_an, e_seg, e_dp, e_err}) begin
        n_fail++;
        $display("FAIL random_%0d: got an=%b seg=%b dp=%b err=%b, want an=%b seg=%b dp=%b err=%b",
                 i, an, seg, dp, err, e_an, e_seg, e_dp, e_err);
      end
    end
    reset = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_load_mid();
    test_load_at_fs();
    test_lz();
    test_illegal();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_drv.md
# seg7_scan_drv

Downstream consumer of the 4-bit one-hot ring counter. The ring counter's `state` word is the digit-select sequence. This block turns it into a registered, active-low 4-digit multiplexed seven-segment drive. Display data is double-buffered and committed only at frame start, so a digit value never changes mid-frame. Ring states that are not one-hot are detected, blanked and flagged.

## Interface
- No parameters. Geometry is fixed at 4 digits × 4-bit hex.
- `clk`  in  1  system clock; same clock as the ring counter.
- `reset`  in  1  synchronous, active-high reset.
- `state`  in  4  ring counter output. One-hot bit i selects digit i. Sequence is 1000→0100→0010→0001→1000.
- `load`  in  1  one-cycle strobe that captures `din`/`dp_mask` into the shadow buffer.
- `din`  in  16  4 hex digits. Digit i = `din[4i+3:4i]`; digit 3 is leftmost.
- `dp_mask`  in  4  decimal-point enables, bit i for digit i.
- `blank_lz`  in  1  leading-zero blanking enable.
- `an`  out  4  digit anodes, active low.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active low.
- `dp`  out  1  decimal point, active low.
- `err`  out  1  sticky flag for an illegal ring state.

## Operation
- **Registers**
  - shadow `{sh_val[15:0], sh_dp[3:0]}` plus `pend` flag.
  - display `{disp_val[15:0], disp_dp[3:0]}`.
  - output regs `an`, `seg`, `dp`; sticky `err`.
- **Load**
  - `load=1`: shadow ← `{din, dp_mask}`, `pend` ← 1.
  - A repeated load before commit overwrites the shadow; last load wins.
- **Frame start** is a cycle with `state==4'b1000`.
  - If `load=1` in that cycle, display ← `{din, dp_mask}` directly and `pend` ← 0. Load wins over the older shadow.
  - Else if `pend=1`, display ← shadow and `pend` ← 0.
  - Else the display register holds.
- **Digit select**, from `state` sampled in cycle t:
  - One-hot: digit i is active. `an` = ~`state`.
  - `4'b0000` is ring-counter idle/reset: all outputs off (`an`=1111, `seg`=1111111, `dp`=1). Not an error.
  - Any other value (≥2 bits set): all outputs off, `err` ← 1. `err` holds until `reset`.
- **Glyph decode** of the active nibble:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- **Leading-zero blanking** (`blank_lz=1`)
  - Digit i (i=3..1) is blanked when its nibble and every higher nibble are 0.
  - Blanking forces `seg`=1111111, but `an` still drives the digit.
  - Digit 0 is never blanked.
  - A blanked digit still shows its dp if its `disp_dp` bit is set.
- `dp` = ~`disp_dp[i]` for the active digit.
- Decode uses the display register value *after* any same-cycle commit: a load at frame start shows on digit 3 of that same frame.

## Timing
- All outputs are registered. `an`/`seg`/`dp` reflect the `state` sampled one cycle earlier (latency 1).
- `err` asserts in the cycle after the illegal `state` is sampled.
- **Reset** (synchronous, highest priority):
  - `an`=1111, `seg`=1111111, `dp`=1, `err`=0.
  - `pend`=0; shadow and display = 0.
- **Reset mid-frame**: the next cycle is all-off. A pending shadow is discarded.
- **Load with no frame start**: the display is unchanged indefinitely. `pend` stays 1 until the next `state==1000`.
- **Ring stuck at 0000**: no frame start occurs, so no commit occurs. Outputs stay off.
- **Illegal state at a frame start**: not possible, since 1000 is legal. An illegal state never commits the shadow.

## Test plan
- **Reset, then frame**: `reset` 1 cycle, then ring 1000→0100→0010→0001. With display 0 and `blank_lz=0`:
  - `an` = 0111, 1011, 1101, 1110 on cycles t+1..t+4.
  - `seg`=1000000 on each.
- **Load mid-frame**: `load` `din`=16'h1234 while `state`=0100.
  - The current frame keeps showing 0.
  - Next frame: `seg` = 1111001, 0100100, 0110000, 0011001 for digits 3..0.
- **Load exactly at frame start**: `state`=1000, `load` `din`=16'hABCD. The next cycle shows `an`=0111, `seg`=0001000 (A) immediately. A pending older shadow is discarded.
- **Leading-zero blanking**: `din`=16'h0070, `blank_lz`=1, `dp_mask`=4'b1000.
  - Digit 3: `seg`=1111111, `dp`=0.
  - Digit 2: `seg`=1111111, `dp`=1.
  - Digit 1: `seg`=1111000 (7).
  - Digit 0: `seg`=1000000 (0), not blanked.
- **Illegal state**: drive `state`=4'b0110 for one cycle.
  - Next cycle: `an`=1111, `seg`=1111111, `err`=1.
  - Legal scanning then resumes with `err` still 1.
  - `reset` clears `err` to 0.
- **Idle 0000**: hold `state`=0000 while `load` 16'hFFFF is applied. Outputs stay off and `err`=0.
  - Release the ring at 1000: the next cycle shows `seg`=0001110 (F).
